mcs8_bus_ctrl: RTL and testbench

System-side bus controller for the MCS8 core: the responder that sits on the far end of the CPU's multiplexed bus and decodes the CPU's 3-bit state code and SYNC into memory and I/O transactions. It latches the 14-bit address from T1/T2, decodes the cycle type, inserts wait states through READY, drives read data back during T3, and captures write and OUT data. It also runs the interrupt handshake, jamming an RST instruction into the T1I-initiated fetch.

---
 rtl/mcs8_bus_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_mcs8_bus_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcs8_bus_ctrl.sv
// -----------------------------------------------------------------------------
// mcs8_bus_ctrl
//   System-side responder for the MCS8 multiplexed bus. It decodes the CPU
//   state code and SYNC and turns them into memory and I/O transactions:
//   it latches the 14-bit address from T1/T2 and decodes the cycle type.
//   It inserts wait states through READY_O, opens a read window that exactly
//   covers T3, and captures write/OUT data as one-clock pulses after T3.
//
// Parameters
//   WAIT_STATES  wait periods inserted per cycle (0..15)
//
// Ports
//   CLK1_I       clock, all logic on posedge
//   nRST_I       asynchronous active-low reset
//   SYNC_I       phase qualifier; a tick is a posedge with SYNC_I=1
//   STATE_I      CPU state code
//   D_I          CPU bus (addr low / {cycle,addr hi} / write data)
//   RDATA_I      memory / input-port read data
//   MEM_READY_I  external ready, ANDed into READY_O
//   INT_REQ_I    interrupt request (level)
//   INT_VEC_I    RST vector for the pending interrupt
//   READY_O      ready to CPU
//   INT_O        interrupt request to CPU
//   INT_ACK_O    one-clock acknowledge pulse on the T1I tick
//   ADDR_O       {addr_hi[5:0], addr_lo}
//   CYC_O        cycle type: 00 PCI, 01 PCR, 10 PCC, 11 PCW
//   MEM_RD_O     memory read window (level, spans T3)
//   IO_RD_O      input-port read window (level, spans T3)
//   MEM_WR_O     one-clock memory write pulse
//   IO_WR_O      one-clock OUT pulse
//   WDATA_O      write / OUT data
//   DATA_O       data returned to CPU
//   DATA_OE_O    bus drive enable
//   IO_PORT_O    port number, addr_hi[5:1]
//   HALT_O       CPU is in STOP
//
// Configuration
//   MCS8_BUS_INT_EN  defined: interrupt handshake with RST jamming.
//                    undefined: INT_O/INT_ACK_O tied low, no jamming.
// -----------------------------------------------------------------------------
module mcs8_bus_ctrl #(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        CLK1_I,
  input  logic        nRST_I,
  input  logic        SYNC_I,
  input  logic [2:0]  STATE_I,
  input  logic [7:0]  D_I,
  input  logic [7:0]  RDATA_I,
  input  logic        MEM_READY_I,
  input  logic        INT_REQ_I,
  input  logic [2:0]  INT_VEC_I,
  output logic        READY_O,
  output logic        INT_O,
  output logic        INT_ACK_O,
  output logic [13:0] ADDR_O,
  output logic [1:0]  CYC_O,
  output logic        MEM_RD_O,
  output logic        IO_RD_O,
  output logic        MEM_WR_O,
  output logic        IO_WR_O,
  output logic [7:0]  WDATA_O,
  output logic [7:0]  DATA_O,
  output logic        DATA_OE_O,
  output logic [4:0]  IO_PORT_O,
  output logic        HALT_O
);

  typedef enum logic [2:0] {
    ST_WAIT = 3'b000,
    ST_T3   = 3'b001,
    ST_T1   = 3'b010,
    ST_STOP = 3'b011,
    ST_T2   = 3'b100,
    ST_T5   = 3'b101,
    ST_T1I  = 3'b110,
    ST_T4   = 3'b111
  } state_e;

  typedef enum logic [1:0] {
    CYC_PCI = 2'b00,
    CYC_PCR = 2'b01,
    CYC_PCC = 2'b10,
    CYC_PCW = 2'b11
  } cyc_e;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_e      st;
  logic [7:0]  addr_lo_q;
  logic [13:0] addr_q;
  logic [1:0]  cyc_q;
  logic [3:0]  wait_cnt_q;
  logic        mem_rd_q, io_rd_q, data_oe_q, jam_win_q;
  logic        mem_wr_q, io_wr_q;
  logic [7:0]  wdata_q;

  // Interrupt state; constant-driven when the feature is compiled out.
  logic        int_q, ack_q, jam_q;
  logic [2:0]  vec_q;

  logic        tick_t1, tick_t1i, tick_t2, tick_addr, tick_t3, grant;
  logic [1:0]  cyc_sel;
  logic [4:0]  port_sel;
  logic        rd_mem, rd_io, jam_open;

  assign st = state_e'(STATE_I);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    tick_t1   = 1'b0;
    tick_t1i  = 1'b0;
    tick_t2   = 1'b0;
    tick_addr = 1'b0;
    tick_t3   = 1'b0;
    if (SYNC_I) begin
      tick_t1   = (st == ST_T1) || (st == ST_T1I);
      tick_t1i  = (st == ST_T1I);
      tick_t2   = (st == ST_T2);
      tick_addr = (st == ST_T2) || (st == ST_WAIT);
      tick_t3   = (st == ST_T3);
    end
    // On the T2 tick the cycle type and port are still on D_I; on a WAIT
    // tick they come from the registered copies.
    cyc_sel  = tick_t2 ? D_I[7:6] : cyc_q;
    port_sel = tick_t2 ? D_I[5:1] : addr_q[13:9];
  end

  assign READY_O  = (wait_cnt_q == 4'd0) && MEM_READY_I;
  assign grant    = tick_addr && READY_O;   // CPU moves to T3 on this tick
  assign rd_mem   = grant && ((cyc_sel == CYC_PCI) || (cyc_sel == CYC_PCR));
  assign rd_io    = grant && (cyc_sel == CYC_PCC) && (port_sel[4:3] == 2'b00);
  assign jam_open = rd_mem && (cyc_sel == CYC_PCI) && jam_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK1_I or negedge nRST_I) begin
    if (!nRST_I) begin
      addr_lo_q  <= '0;
      addr_q     <= '0;
      cyc_q      <= '0;
      wait_cnt_q <= '0;
      mem_rd_q   <= 1'b0;
      io_rd_q    <= 1'b0;
      data_oe_q  <= 1'b0;
      jam_win_q  <= 1'b0;
      mem_wr_q   <= 1'b0;
      io_wr_q    <= 1'b0;
      wdata_q    <= '0;
    end else begin
      // Write strobes are single-clock pulses, cleared on every edge.
      mem_wr_q <= 1'b0;
      io_wr_q  <= 1'b0;
      if (tick_t1) begin
        addr_lo_q  <= D_I;
        wait_cnt_q <= WAIT_INIT;
      end
      if (tick_t2) begin
        addr_q <= {D_I[5:0], addr_lo_q};
        cyc_q  <= D_I[7:6];
      end
      if (tick_addr && (wait_cnt_q != 4'd0)) begin
        wait_cnt_q <= wait_cnt_q - 4'd1;
      end
      if (rd_mem || rd_io) begin
        data_oe_q <= 1'b1;
        mem_rd_q  <= rd_mem && !jam_open;   // jammed fetch never reaches memory
        io_rd_q   <= rd_io;
        jam_win_q <= jam_open;
      end
      if (tick_t3) begin
        mem_rd_q  <= 1'b0;
        io_rd_q   <= 1'b0;
        data_oe_q <= 1'b0;
        jam_win_q <= 1'b0;
        if (cyc_q == CYC_PCW) begin
          mem_wr_q <= 1'b1;
          wdata_q  <= D_I;
        end else if ((cyc_q == CYC_PCC) && (addr_q[13:12] != 2'b00)) begin
          // OUT: the accumulator was sent as the low address byte in T1.
          io_wr_q <= 1'b1;
          wdata_q <= addr_lo_q;
        end
      end
    end
  end

`ifdef MCS8_BUS_INT_EN
  always_ff @(posedge CLK1_I or negedge nRST_I) begin
    if (!nRST_I) begin
      int_q <= 1'b0;
      ack_q <= 1'b0;
      jam_q <= 1'b0;
      vec_q <= '0;
    end else begin
      ack_q <= 1'b0;
      if (tick_t1i) begin
        int_q <= 1'b0;
        ack_q <= 1'b1;
        jam_q <= 1'b1;
        vec_q <= INT_VEC_I;
      end else begin
        if (SYNC_I && INT_REQ_I && !jam_q) int_q <= 1'b1;
        if (tick_t3 && jam_win_q)          jam_q <= 1'b0;
      end
    end
  end
`else
  logic unused_int;
  assign unused_int = ^{INT_REQ_I, INT_VEC_I, tick_t1i};
  assign int_q = 1'b0;
  assign ack_q = 1'b0;
  assign jam_q = 1'b0;
  assign vec_q = '0;
`endif

  assign INT_O     = int_q;
  assign INT_ACK_O = ack_q;
  assign ADDR_O    = addr_q;
  assign CYC_O     = cyc_q;
  assign MEM_RD_O  = mem_rd_q;
  assign IO_RD_O   = io_rd_q;
  assign MEM_WR_O  = mem_wr_q;
  assign IO_WR_O   = io_wr_q;
  assign WDATA_O   = wdata_q;
  assign DATA_OE_O = data_oe_q;
  assign DATA_O    = !data_oe_q ? 8'h00 :
                     jam_win_q  ? {2'b00, vec_q, 3'b101} : RDATA_I;
  assign IO_PORT_O = addr_q[13:9];
  assign HALT_O    = (st == ST_STOP);

endmodule

// File: tb/tb_mcs8_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mcs8_bus_ctrl
//   Bench for mcs8_bus_ctrl. A vector table drives CPU bus states into a
//   WAIT_STATES=0 instance; expected outputs are queued as each vector is
//   driven and compared after the clock edge. Hand-written sequences cover
//   wait states (second instance, WAIT_STATES=2), interrupts and mid-cycle
//   reset. Honours MCS8_BUS_INT_EN.
// -----------------------------------------------------------------------------
module tb_mcs8_bus_ctrl;

  localparam logic [2:0] S_WAIT = 3'b000, S_T3 = 3'b001, S_T1 = 3'b010,
                         S_STOP = 3'b011, S_T2 = 3'b100, S_T5 = 3'b101,
                         S_T1I = 3'b110, S_T4 = 3'b111;

  typedef struct packed {
    logic        ready;
    logic        int_o;
    logic        ack;
    logic [13:0] addr;
    logic [1:0]  cyc;
    logic        mem_rd;
    logic        io_rd;
    logic        mem_wr;
    logic        io_wr;
    logic [7:0]  wdata;
    logic [7:0]  data;
    logic        oe;
    logic [4:0]  port;
    logic        halt;
  } obs_t;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic [7:0] d;
    logic       sync;
    logic [7:0] rdata;
    logic       mrdy;
    obs_t       exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sync_i;
  logic [2:0]  state_i;
  logic [7:0]  d_i, rdata_i;
  logic        mem_ready_i, int_req_i;
  logic [2:0]  int_vec_i;

  logic        ready0, int0, ack0, mrd0, iord0, mwr0, iowr0, oe0, halt0;
  logic [13:0] addr0;
  logic [1:0]  cyc0;
  logic [7:0]  wdata0, data0;
  logic [4:0]  port0;

  logic        ready2, int2, ack2, mrd2, iord2, mwr2, iowr2, oe2, halt2;
  logic [13:0] addr2;
  logic [1:0]  cyc2;
  logic [7:0]  wdata2, data2;
  logic [4:0]  port2;

  int total = 0;
  int bad   = 0;

  vec_t vecs[$];
  obs_t sb_q[$];

  always #5 clk = ~clk;

  mcs8_bus_ctrl #(.WAIT_STATES(0)) dut0 (
    .CLK1_I(clk), .nRST_I(rst_n), .SYNC_I(sync_i), .STATE_I(state_i),
    .D_I(d_i), .RDATA_I(rdata_i), .MEM_READY_I(mem_ready_i),
    .INT_REQ_I(int_req_i), .INT_VEC_I(int_vec_i),
    .READY_O(ready0), .INT_O(int0), .INT_ACK_O(ack0), .ADDR_O(addr0),
    .CYC_O(cyc0), .MEM_RD_O(mrd0), .IO_RD_O(iord0), .MEM_WR_O(mwr0),
    .IO_WR_O(iowr0), .WDATA_O(wdata0), .DATA_O(data0), .DATA_OE_O(oe0),
    .IO_PORT_O(port0), .HALT_O(halt0)
  );

  mcs8_bus_ctrl #(.WAIT_STATES(2)) dut2 (
    .CLK1_I(clk), .nRST_I(rst_n), .SYNC_I(sync_i), .STATE_I(state_i),
    .D_I(d_i), .RDATA_I(rdata_i), .MEM_READY_I(mem_ready_i),
    .INT_REQ_I(int_req_i), .INT_VEC_I(int_vec_i),
    .READY_O(ready2), .INT_O(int2), .INT_ACK_O(ack2), .ADDR_O(addr2),
    .CYC_O(cyc2), .MEM_RD_O(mrd2), .IO_RD_O(iord2), .MEM_WR_O(mwr2),
    .IO_WR_O(iowr2), .WDATA_O(wdata2), .DATA_O(data2), .DATA_OE_O(oe2),
    .IO_PORT_O(port2), .HALT_O(halt2)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic obs_t get_obs0();
    obs_t o;
    o.ready = ready0; o.int_o = int0;  o.ack    = ack0;  o.addr  = addr0;
    o.cyc   = cyc0;   o.mem_rd = mrd0; o.io_rd  = iord0; o.mem_wr = mwr0;
    o.io_wr = iowr0;  o.wdata = wdata0; o.data  = data0; o.oe    = oe0;
    o.port  = port0;  o.halt  = halt0;
    return o;
  endfunction

  function automatic obs_t mk(input logic ready, input logic [13:0] addr,
                              input logic [1:0] cyc, input logic mrd,
                              input logic iord, input logic mwr,
                              input logic iowr, input logic [7:0] wdata,
                              input logic [7:0] data, input logic oe,
                              input logic halt);
    obs_t o;
    o.ready = ready; o.int_o = 1'b0; o.ack = 1'b0; o.addr = addr;
    o.cyc = cyc; o.mem_rd = mrd; o.io_rd = iord; o.mem_wr = mwr;
    o.io_wr = iowr; o.wdata = wdata; o.data = data; o.oe = oe;
    o.port = addr[13:9]; o.halt = halt;
    return o;
  endfunction

  task automatic add(input string name, input logic [2:0] st,
                     input logic [7:0] d, input logic sync,
                     input logic [7:0] rdata, input logic mrdy, input obs_t e);
    vec_t v;
    v.name = name; v.st = st; v.d = d; v.sync = sync;
    v.rdata = rdata; v.mrdy = mrdy; v.exp = e;
    vecs.push_back(v);
  endtask

  // Drive one bus state at the falling edge and return #1 after the rising edge.
  task automatic step(input logic [2:0] st, input logic [7:0] d);
    @(negedge clk);
    state_i = st;
    d_i     = d;
    sync_i  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; sync_i = 1'b1; state_i = S_T4; d_i = 8'h00;
    rdata_i = 8'h9C; mem_ready_i = 1'b1; int_req_i = 1'b0; int_vec_i = 3'd0;

    // Expected bus behaviour, one record per tick.
    add("fetch_t1",  S_T1,   8'h34, 1, 8'h9C, 1, mk(1, 14'h0000, 0, 0,0,0,0, 8'h00, 8'h00, 0, 0));
    add("fetch_t2",  S_T2,   8'h12, 1, 8'h9C, 1, mk(1, 14'h1234, 0, 1,0,0,0, 8'h00, 8'h9C, 1, 0));
    add("fetch_t3",  S_T3,   8'h00, 1, 8'h9C, 1, mk(1, 14'h1234, 0, 0,0,0,0, 8'h00, 8'h00, 0, 0));
    add("wr_t1",     S_T1,   8'h21, 1, 8'h9C, 1, mk(1, 14'h1234, 0, 0,0,0,0, 8'h00, 8'h00, 0, 0));
    add("wr_t2",     S_T2,   8'hC5, 1, 8'h9C, 1, mk(1, 14'h0521, 3, 0,0,0,0, 8'h00, 8'h00, 0, 0));
    add("wr_t3",     S_T3,   8'hA7, 1, 8'h9C, 1, mk(1, 14'h0521, 3, 0,0,1,0, 8'hA7, 8'h00, 0, 0));
    add("wr_t4",     S_T4,   8'h00, 1, 8'h9C, 1, mk(1, 14'h0521, 3, 0,0,0,0, 8'hA7, 8'h00, 0, 0));
    add("out_t1",    S_T1,   8'h5A, 1, 8'h9C, 1, mk(1, 14'h0521, 3, 0,0,0,0, 8'hA7, 8'h00, 0, 0));
    add("out_t2",    S_T2,   8'h90, 1, 8'h9C, 1, mk(1, 14'h105A, 2, 0,0,0,0, 8'hA7, 8'h00, 0, 0));
    add("out_t3",    S_T3,   8'h00, 1, 8'h9C, 1, mk(1, 14'h105A, 2, 0,0,0,1, 8'h5A, 8'h00, 0, 0));
    add("out_t5",    S_T5,   8'h00, 1, 8'h9C, 1, mk(1, 14'h105A, 2, 0,0,0,0, 8'h5A, 8'h00, 0, 0));
    add("inp_t1",    S_T1,   8'h07, 1, 8'h9C, 1, mk(1, 14'h105A, 2, 0,0,0,0, 8'h5A, 8'h00, 0, 0));
    add("inp_t2",    S_T2,   8'h86, 1, 8'h9C, 1, mk(1, 14'h0607, 2, 0,1,0,0, 8'h5A, 8'h9C, 1, 0));
    add("inp_t3",    S_T3,   8'h00, 1, 8'h9C, 1, mk(1, 14'h0607, 2, 0,0,0,0, 8'h5A, 8'h00, 0, 0));
    add("nosync_t1", S_T1,   8'hFF, 0, 8'h9C, 1, mk(1, 14'h0607, 2, 0,0,0,0, 8'h5A, 8'h00, 0, 0));
    add("hold_t2",   S_T2,   8'h01, 1, 8'h3E, 1, mk(1, 14'h0107, 0, 1,0,0,0, 8'h5A, 8'h3E, 1, 0));
    add("hold_t3",   S_T3,   8'h00, 1, 8'h3E, 1, mk(1, 14'h0107, 0, 0,0,0,0, 8'h5A, 8'h00, 0, 0));
    add("pcr_t1",    S_T1,   8'h10, 1, 8'h9C, 1, mk(1, 14'h0107, 0, 0,0,0,0, 8'h5A, 8'h00, 0, 0));
    add("pcr_t2",    S_T2,   8'h40, 1, 8'h9C, 0, mk(0, 14'h0010, 1, 0,0,0,0, 8'h5A, 8'h00, 0, 0));
    add("pcr_wait",  S_WAIT, 8'h00, 1, 8'h9C, 1, mk(1, 14'h0010, 1, 1,0,0,0, 8'h5A, 8'h9C, 1, 0));
    add("pcr_t3",    S_T3,   8'h00, 1, 8'h9C, 1, mk(1, 14'h0010, 1, 0,0,0,0, 8'h5A, 8'h00, 0, 0));
    add("stop",      S_STOP, 8'h00, 1, 8'h9C, 1, mk(1, 14'h0010, 1, 0,0,0,0, 8'h5A, 8'h00, 0, 1));

    // Reset state.
    #12;
    check("reset_obs", 64'(get_obs0()), 64'(mk(1, 14'h0000, 0, 0,0,0,0, 8'h00, 8'h00, 0, 0)));
    check("reset_ready2", 64'(ready2), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors through the scoreboard.
    for (int i = 0; i < vecs.size(); i++) begin
      obs_t e;
      @(negedge clk);
      state_i     = vecs[i].st;
      d_i         = vecs[i].d;
      sync_i      = vecs[i].sync;
      rdata_i     = vecs[i].rdata;
      mem_ready_i = vecs[i].mrdy;
      sb_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check(vecs[i].name, 64'(get_obs0()), 64'(e));
    end
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    // WAIT_STATES=2 on dut2: READY low at T2 and first WAIT, high at second.
    rdata_i = 8'h61; mem_ready_i = 1'b1;
    step(S_T1, 8'h00);
    check("ws2_ready_at_t2", 64'(ready2), 64'd0);
    step(S_T2, 8'h00);
    check("ws2_ready_at_wait1", 64'(ready2), 64'd0);
    check("ws2_no_rd_early", 64'(mrd2), 64'd0);
    step(S_WAIT, 8'h00);
    check("ws2_ready_at_wait2", 64'(ready2), 64'd1);
    check("ws2_no_rd_wait1", 64'(mrd2), 64'd0);
    step(S_WAIT, 8'h00);
    check("ws2_rd_open", 64'({mrd2, oe2, data2}), 64'({1'b1, 1'b1, 8'h61}));
    step(S_T3, 8'h00);
    check("ws2_rd_close", 64'({mrd2, oe2}), 64'd0);

    // Interrupt handshake and RST jamming.
    rdata_i = 8'h77;
    int_req_i = 1'b1; int_vec_i = 3'd5;
    step(S_T4, 8'h00);
`ifdef MCS8_BUS_INT_EN
    check("int_raised", 64'(int0), 64'd1);
    int_req_i = 1'b0;
    step(S_T1I, 8'h00);
    check("int_ack", 64'({int0, ack0}), 64'({1'b0, 1'b1}));
    step(S_T2, 8'h00);
    check("int_ack_pulse", 64'(ack0), 64'd0);
    check("int_jam", 64'({mrd0, oe0, data0}), 64'({1'b0, 1'b1, 8'h2D}));
    step(S_T3, 8'h00);
    check("int_jam_close", 64'({oe0, data0}), 64'd0);
    step(S_T1, 8'h00);
    step(S_T2, 8'h00);
    check("int_jam_cleared", 64'({mrd0, oe0, data0}), 64'({1'b1, 1'b1, 8'h77}));
    step(S_T3, 8'h00);
`else
    check("int_off", 64'(int0), 64'd0);
    int_req_i = 1'b0;
    step(S_T1I, 8'h00);
    check("int_off_ack", 64'(ack0), 64'd0);
    step(S_T2, 8'h00);
    check("int_off_fetch", 64'({mrd0, oe0, data0}), 64'({1'b1, 1'b1, 8'h77}));
    step(S_T3, 8'h00);
`endif

    // Reset asserted mid-T3 of a PCR cycle.
    step(S_T1, 8'h99);
    step(S_T2, 8'h4A);
    check("rst_pre", 64'({addr0, mrd0, oe0}), 64'({14'h0A99, 1'b1, 1'b1}));
    @(negedge clk);
    state_i = S_T3;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid", 64'({addr0, cyc0, mrd0, iord0, mwr0, iowr0, oe0, data0}), 64'd0);
    check("rst_mid_ws2", 64'({mrd2, oe2, addr2}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
